// File: rtl/muldiv_seq_unit_if.sv
// Request/response bundle between the main control FSM and the iterative
// RV32M multiply/divide unit.
interface muldiv_seq_unit_if #(
  parameter int XLEN = 32
);
  // Handshake: start is taken only in a cycle where busy = 0, and funct3/src_a/src_b
  // are captured in that same cycle. busy then stays high until done has pulsed for
  // one cycle, and result is valid in the done cycle and held until the next done.
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, src_a, src_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, src_a, src_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up at the end.
module muldiv_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  muldiv_seq_unit_if.slave bus,
  output logic [1:0]       fsm_state
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [2:0]        op;
  logic              neg_a;
  logic              neg_b;
  logic              div_zero;
  logic [XLEN-1:0]   raw_a;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   result;

  // Operand decode for the request currently presented on the bus.
  logic            signed_a_in;
  logic            signed_b_in;
  logic            neg_a_in;
  logic            neg_b_in;
  logic            div_zero_in;
  logic [XLEN-1:0] mag_a_in;
  logic [XLEN-1:0] mag_b_in;

  always_comb begin
    signed_a_in = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) &&
                  (bus.funct3 != 3'b111);
    signed_b_in = signed_a_in && (bus.funct3 != 3'b010);
    neg_a_in    = signed_a_in && bus.src_a[XLEN-1];
    neg_b_in    = signed_b_in && bus.src_b[XLEN-1];
    mag_a_in    = neg_a_in ? -bus.src_a : bus.src_a;
    mag_b_in    = neg_b_in ? -bus.src_b : bus.src_b;
    div_zero_in = bus.funct3[2] && (bus.src_b == '0);
  end

  // One iteration of each algorithm. Multiply keeps the multiplier in the low half
  // and shifts the product in from the top; divide shifts the dividend out of the
  // low half into the partial remainder and shifts quotient bits in at the bottom.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_hi;
  logic [XLEN:0]     div_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_hi   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_sub  = div_hi - {1'b0, mag_b};
    div_ge   = div_hi >= {1'b0, mag_b};
    div_next = {(div_ge ? div_sub[XLEN-1:0] : div_hi[XLEN-1:0]),
                acc[XLEN-2:0], div_ge};
  end

  // Sign correction and output-half selection applied in FIX.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    prod    = (neg_a ^ neg_b) ? -acc : acc;
    quot    = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem     = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_val = '0;
    case (op)
      3'b000:                 fix_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = div_zero ? '1 : quot;
      default:                fix_val = div_zero ? raw_a : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      raw_a    <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op       <= bus.funct3;
            neg_a    <= neg_a_in;
            neg_b    <= neg_b_in;
            div_zero <= div_zero_in;
            raw_a    <= bus.src_a;
            mag_a    <= mag_a_in;
            mag_b    <= mag_b_in;
            acc      <= bus.funct3[2] ? {{XLEN{1'b0}}, mag_a_in}
                                      : {{XLEN{1'b0}}, mag_b_in};
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= div_zero_in ? FIX : CALC;
          end
        end
        CALC: begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result <= fix_val;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;
  assign fsm_state  = state;
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Bench for muldiv_seq_unit: XLEN=32 directed table and XLEN=8 random sweep,
// both compared every cycle against an arithmetic reference model.
module tb_muldiv_seq_unit;
  typedef struct {
    int          scyc;
    int          dcyc;
    logic [63:0] res;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst32 = 1'b1;
  logic       rst8  = 1'b1;
  logic [1:0] st32;
  logic [1:0] st8;
  int         cyc    = 0;
  int         n_cmp  = 0;
  int         n_fail = 0;

  muldiv_seq_unit_if #(.XLEN(32)) if32 ();
  muldiv_seq_unit_if #(.XLEN(8))  if8 ();

  muldiv_seq_unit #(.XLEN(32)) u32 (.clk(clk), .reset(rst32), .bus(if32), .fsm_state(st32));
  muldiv_seq_unit #(.XLEN(8))  u8  (.clk(clk), .reset(rst8),  .bus(if8),  .fsm_state(st8));

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_model(input int xl, input logic [2:0] f3,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    longint      ua, ub, sa, sb, p;
    mask = (64'd1 << xl) - 64'd1;
    ua   = longint'(a & mask);
    ub   = longint'(b & mask);
    sa   = (ua << (64 - xl)) >>> (64 - xl);
    sb   = (ub << (64 - xl)) >>> (64 - xl);
    case (f3)
      3'b000:  p = sa * sb;
      3'b001:  p = (sa * sb) >>> xl;
      3'b010:  p = (sa * ub) >>> xl;
      3'b011:  p = (ua * ub) >> xl;
      3'b100:  p = (ub == 0) ? -64'sd1 : sa / sb;
      3'b101:  p = (ub == 0) ? -64'sd1 : ua / ub;
      3'b110:  p = (ub == 0) ? sa : sa % sb;
      default: p = (ub == 0) ? ua : ua % ub;
    endcase
    return 64'(p) & mask;
  endfunction

  // ---------------- scoreboard / compare, XLEN=32 ----------------
  exp_t        exp_q32[$];
  logic [63:0] last32 = '0;
  int          free32 = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic        exp_done;
    logic        exp_busy;
    logic [63:0] exp_res;
    if (cyc > 0) begin
      exp_done = 1'b0;
      exp_busy = 1'b0;
      exp_res  = last32;
      if (exp_q32.size() > 0) begin
        exp_busy = (cyc > exp_q32[0].scyc) && (cyc <= exp_q32[0].dcyc);
        if (exp_q32[0].dcyc == cyc) begin
          exp_done = 1'b1;
          exp_res  = exp_q32[0].res;
          last32   = exp_res;
          void'(exp_q32.pop_front());
        end
      end
      check("u32_done",   64'(if32.done),       64'(exp_done));
      check("u32_busy",   64'(if32.busy),       64'(exp_busy));
      check("u32_result", 64'(if32.result),     exp_res);
      check("u32_state",  64'(st32 != 2'd0),    64'(exp_busy));
    end
    if (rst32) begin
      exp_q32.delete();
      last32 = '0;
      free32 = cyc + 1;
    end else if (if32.start && cyc >= free32) begin
      e.scyc = cyc;
      e.dcyc = cyc + ((if32.funct3[2] && if32.src_b == '0) ? 2 : 34);
      e.res  = ref_model(32, if32.funct3, 64'(if32.src_a), 64'(if32.src_b));
      exp_q32.push_back(e);
      free32 = e.dcyc + 1;
    end
  end

  // ---------------- scoreboard / compare, XLEN=8 ----------------
  exp_t        exp_q8[$];
  logic [63:0] last8 = '0;
  int          free8 = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic        exp_done;
    logic        exp_busy;
    logic [63:0] exp_res;
    if (cyc > 0) begin
      exp_done = 1'b0;
      exp_busy = 1'b0;
      exp_res  = last8;
      if (exp_q8.size() > 0) begin
        exp_busy = (cyc > exp_q8[0].scyc) && (cyc <= exp_q8[0].dcyc);
        if (exp_q8[0].dcyc == cyc) begin
          exp_done = 1'b1;
          exp_res  = exp_q8[0].res;
          last8    = exp_res;
          void'(exp_q8.pop_front());
        end
      end
      check("u8_done",   64'(if8.done),    64'(exp_done));
      check("u8_busy",   64'(if8.busy),    64'(exp_busy));
      check("u8_result", 64'(if8.result),  exp_res);
      check("u8_state",  64'(st8 != 2'd0), 64'(exp_busy));
    end
    if (rst8) begin
      exp_q8.delete();
      last8 = '0;
      free8 = cyc + 1;
    end else if (if8.start && cyc >= free8) begin
      e.scyc = cyc;
      e.dcyc = cyc + ((if8.funct3[2] && if8.src_b == '0) ? 2 : 10);
      e.res  = ref_model(8, if8.funct3, 64'(if8.src_a), 64'(if8.src_b));
      exp_q8.push_back(e);
      free8 = e.dcyc + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int c);
    step();
    if32.start  = 1'b1;
    if32.funct3 = f3;
    if32.src_a  = a;
    if32.src_b  = b;
    c = cyc;
    step();
    if32.start  = 1'b0;
    if32.funct3 = 3'($urandom_range(0, 7));
    if32.src_a  = $urandom();
    if32.src_b  = $urandom();
  endtask

  task automatic wait32(input int c, output logic [63:0] r, output int lat);
    int k;
    k = 0;
    while (!if32.done && k < 200) begin
      step();
      k++;
    end
    check("u32_done_seen", 64'(if32.done), 64'd1);
    r   = 64'(if32.result);
    lat = cyc - c;
  endtask

  task automatic start8(input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b,
                        output int c);
    step();
    if8.start  = 1'b1;
    if8.funct3 = f3;
    if8.src_a  = a;
    if8.src_b  = b;
    c = cyc;
    step();
    if8.start  = 1'b0;
    if8.src_a  = 8'($urandom());
    if8.src_b  = 8'($urandom());
  endtask

  // Throws stray start pulses at the busy unit while waiting; they must be ignored.
  task automatic wait8(input int c, output int lat);
    int k;
    k = 0;
    while (!if8.done && k < 100) begin
      if8.start  = ($urandom_range(0, 5) == 0);
      if8.funct3 = 3'($urandom_range(0, 7));
      if8.src_a  = 8'($urandom());
      if8.src_b  = 8'($urandom());
      step();
      k++;
    end
    if8.start = 1'b0;
    check("u8_done_seen", 64'(if8.done), 64'd1);
    lat = cyc - c;
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 6))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'h80;
      3:       return 8'hFF;
      default: return 8'($urandom());
    endcase
  endfunction

  // ---------------- directed table (hand-computed) ----------------
  string       t_name[12] = '{"mul_7xm3", "mulh_min_sq", "mulhu_max_sq", "mulhsu_m1xmax",
                              "div_m7_2", "rem_m7_2", "divu_100_7", "remu_100_7",
                              "divu_by_zero", "rem_by_zero", "div_overflow", "rem_overflow"};
  logic [2:0]  t_f3[12]   = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                              3'b101, 3'b111, 3'b101, 3'b110, 3'b100, 3'b110};
  logic [31:0] t_a[12]    = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                              32'd100, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
  logic [31:0] t_b[12]    = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] t_exp[12]  = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                              32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h00000000};
  int          t_lat[12]  = '{34, 34, 34, 34, 34, 34, 34, 34, 2, 2, 34, 34};

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] r;
    int          c;
    int          lat;
    logic [2:0]  f3;
    logic [7:0]  a8;
    logic [7:0]  b8;

    if32.start = 1'b0; if32.funct3 = '0; if32.src_a = '0; if32.src_b = '0;
    if8.start  = 1'b0; if8.funct3  = '0; if8.src_a  = '0; if8.src_b  = '0;
    repeat (3) step();
    rst32 = 1'b0;
    rst8  = 1'b0;
    step();
    check("reset_busy32",   64'(if32.busy),   64'd0);
    check("reset_done32",   64'(if32.done),   64'd0);
    check("reset_result32", 64'(if32.result), 64'd0);
    check("reset_busy8",    64'(if8.busy),    64'd0);
    check("reset_result8",  64'(if8.result),  64'd0);

    for (int i = 0; i < 12; i++) begin
      start32(t_f3[i], t_a[i], t_b[i], c);
      wait32(c, r, lat);
      check(t_name[i], r, 64'(t_exp[i]));
      check("u32_latency", 64'(lat), 64'(t_lat[i]));
    end

    // A second start in cycle 5 of a running multiply must not disturb it.
    start32(3'b000, 32'd1234, 32'd5678, c);
    repeat (4) step();
    if32.start = 1'b1; if32.funct3 = 3'b100; if32.src_a = 32'd9; if32.src_b = 32'd0;
    step();
    if32.start = 1'b0;
    wait32(c, r, lat);
    check("mul_ignored_start", r, 64'd7006652);
    check("mul_ignored_lat", 64'(lat), 64'd34);

    // Reset in cycle 10 of a running operation aborts it silently.
    start32(3'b001, 32'h12345678, 32'h9ABCDEF0, c);
    repeat (9) step();
    rst32 = 1'b1;
    step();
    rst32 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check("abort_busy",   64'(if32.busy),   64'd0);
      check("abort_done",   64'(if32.done),   64'd0);
      check("abort_result", 64'(if32.result), 64'd0);
      step();
    end

    // start together with reset: request dropped.
    rst32 = 1'b1;
    if32.start = 1'b1; if32.funct3 = 3'b000; if32.src_a = 32'd3; if32.src_b = 32'd3;
    step();
    rst32 = 1'b0;
    if32.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("start_with_reset_busy", 64'(if32.busy), 64'd0);
      step();
    end

    // Random XLEN=32 operations, back to back.
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      start32(f3, $urandom(), ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom(), c);
      wait32(c, r, lat);
    end

    // XLEN=8 random sweep.
    for (int i = 0; i < 1000; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a8 = pick8();
      b8 = pick8();
      start8(f3, a8, b8, c);
      wait8(c, lat);
      check("u8_latency", 64'(lat), (f3[2] && b8 == 8'd0) ? 64'd2 : 64'd10);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
    end

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end
endmodule
